// File: rtl/instruction_fetch.sv
// Instruction fetch sequencer.
// Drives the memory's address register and byte selector to read each 16-bit
// instruction as two bytes: selector 0 is the opcode, selector 1 is the operand.
// The assembled instruction is offered to the decoder over a valid/ready
// handshake. A decoder redirect replaces the normal +1 advance with an
// absolute load, a forward add or a backward subtract on the address register.

package memory_pkg;
    typedef enum logic [2:0] {
        NOP      = 3'd0,
        READ     = 3'd1,
        WRITE    = 3'd2,
        ABSOLUTE = 3'd3,
        REL_ADD  = 3'd4,
        REL_SUB  = 3'd5
    } memory_op_e;
endpackage

module instruction_fetch
    import memory_pkg::*;
#(
    parameter logic [7:0] RESET_VECTOR = 8'h00
) (
    input  logic        clock,
    input  logic        reset,
    output memory_op_e  mem_op,
    output logic        mem_data_word_selector,
    output logic [7:0]  mem_in,
    input  logic [7:0]  mem_out,
    output logic [15:0] instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        redirect_req,
    input  logic [1:0]  redirect_mode,
    input  logic [7:0]  redirect_value,
    output logic        redirect_ack
);

    typedef enum logic [2:0] {
        LOAD     = 3'd0,
        RD0A     = 3'd1,
        RD0B     = 3'd2,
        RD1A     = 3'd3,
        RD1B     = 3'd4,
        HOLD     = 3'd5,
        ADVANCE  = 3'd6,
        REDIRECT = 3'd7
    } fetch_state_e;

    localparam logic [1:0] MODE_ABS  = 2'b00;
    localparam logic [1:0] MODE_FWD  = 2'b01;
    localparam logic [1:0] MODE_BACK = 2'b10;
    localparam logic [1:0] MODE_RSVD = 2'b11;

    fetch_state_e state_r;
    fetch_state_e next_state_s;
    logic [1:0]   mode_r;
    logic [7:0]   value_r;
    logic [15:0]  instr_r;

    memory_op_e   mem_op_s;
    logic         selector_s;
    logic [7:0]   mem_in_s;
    logic         valid_s;
    logic         ack_s;
    logic         accept_s;
    logic         take_redirect_s;

    // Handshake qualification: a redirect is honoured only on an accepting handshake with a non-reserved mode.
    always_comb begin
        accept_s        = valid_s && instr_ready;
        take_redirect_s = accept_s && redirect_req && (redirect_mode != MODE_RSVD);
    end

    // Next-state sequencing through load, the four read cycles, hold and the address update.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            LOAD:     next_state_s = RD0A;
            RD0A:     next_state_s = RD0B;
            RD0B:     next_state_s = RD1A;
            RD1A:     next_state_s = RD1B;
            RD1B:     next_state_s = HOLD;
            HOLD: begin
                if (take_redirect_s) begin
                    next_state_s = REDIRECT;
                end else if (accept_s) begin
                    next_state_s = ADVANCE;
                end else begin
                    next_state_s = HOLD;
                end
            end
            ADVANCE:  next_state_s = RD0A;
            REDIRECT: next_state_s = RD0A;
            default:  next_state_s = LOAD;
        endcase
    end

    // Memory-side and handshake outputs decoded from the state register; forced idle while reset is held.
    always_comb begin
        mem_op_s   = NOP;
        selector_s = 1'b0;
        mem_in_s   = 8'h00;
        valid_s    = 1'b0;
        ack_s      = 1'b0;
        if (reset) begin
            mem_op_s = NOP;
        end else begin
            case (state_r)
                LOAD: begin
                    mem_op_s = ABSOLUTE;
                    mem_in_s = RESET_VECTOR;
                end
                RD0A, RD0B: begin
                    mem_op_s = READ;
                end
                RD1A, RD1B: begin
                    mem_op_s   = READ;
                    selector_s = 1'b1;
                end
                HOLD: begin
                    valid_s = 1'b1;
                end
                ADVANCE: begin
                    mem_op_s = REL_ADD;
                    mem_in_s = 8'h01;
                end
                REDIRECT: begin
                    ack_s = 1'b1;
                    case (mode_r)
                        MODE_ABS: begin
                            mem_op_s = ABSOLUTE;
                            mem_in_s = value_r;
                        end
                        MODE_FWD: begin
                            mem_op_s = REL_ADD;
                            mem_in_s = value_r;
                        end
                        MODE_BACK: begin
                            mem_op_s = REL_SUB;
                            mem_in_s = value_r;
                        end
                        default: begin
                            mem_op_s = NOP;
                            mem_in_s = 8'h00;
                        end
                    endcase
                end
                default: begin
                    mem_op_s = NOP;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= LOAD;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Latch the redirect request at the accepting handshake so it survives until the REDIRECT cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            mode_r  <= 2'b00;
            value_r <= 8'h00;
        end else if (take_redirect_s) begin
            mode_r  <= redirect_mode;
            value_r <= redirect_value;
        end else begin
            mode_r  <= mode_r;
            value_r <= value_r;
        end
    end

    // Capture opcode at the end of RD0B and operand at the end of RD1B; reset discards any partial word.
    always_ff @(posedge clock) begin
        if (reset) begin
            instr_r <= 16'h0000;
        end else if (state_r == RD0B) begin
            instr_r[15:8] <= mem_out;
        end else if (state_r == RD1B) begin
            instr_r[7:0] <= mem_out;
        end else begin
            instr_r <= instr_r;
        end
    end

    assign mem_op                 = mem_op_s;
    assign mem_data_word_selector = selector_s;
    assign mem_in                 = mem_in_s;
    assign instr                  = instr_r;
    assign instr_valid            = valid_s;
    assign redirect_ack           = ack_s;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a behavioural model of the
// byte-addressable word memory (address register, registered read).

module tb_instruction_fetch;
    import memory_pkg::*;

    logic        clock;
    logic        reset;
    memory_op_e  mem_op;
    logic        mem_sel;
    logic [7:0]  mem_in;
    logic [7:0]  mem_out;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect_req;
    logic [1:0]  redirect_mode;
    logic [7:0]  redirect_value;
    logic        redirect_ack;

    int checks;
    int errors;

    logic [15:0] mem [0:255];
    logic [7:0]  mem_addr;

    instruction_fetch dut (
        .clock                  (clock),
        .reset                  (reset),
        .mem_op                 (mem_op),
        .mem_data_word_selector (mem_sel),
        .mem_in                 (mem_in),
        .mem_out                (mem_out),
        .instr                  (instr),
        .instr_valid            (instr_valid),
        .instr_ready            (instr_ready),
        .redirect_req           (redirect_req),
        .redirect_mode          (redirect_mode),
        .redirect_value         (redirect_value),
        .redirect_ack           (redirect_ack)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory model: address register plus a read registered on the clock edge.
    always @(posedge clock) begin
        case (mem_op)
            READ:     mem_out  <= mem_sel ? mem[mem_addr][7:0] : mem[mem_addr][15:8];
            ABSOLUTE: mem_addr <= mem_in;
            REL_ADD:  mem_addr <= mem_addr + mem_in;
            REL_SUB:  mem_addr <= mem_addr - mem_in;
            default:  ;
        endcase
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Reset for two edges, release, leave the bench in cycle 0 (LOAD).
    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        #1;
    endtask

    // Advance until instr_valid is seen; n = edges taken, -1 on timeout.
    task automatic wait_valid(output int n);
        n = 0;
        while (instr_valid !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        if (instr_valid !== 1'b1) n = -1;
    endtask

    task automatic test_reset();
        memory_op_e exp_op [0:5];
        logic       exp_sel [0:5];
        int n;
        exp_op[0] = ABSOLUTE; exp_op[1] = READ; exp_op[2] = READ;
        exp_op[3] = READ;     exp_op[4] = READ; exp_op[5] = NOP;
        exp_sel[0] = 1'b0; exp_sel[1] = 1'b0; exp_sel[2] = 1'b0;
        exp_sel[3] = 1'b1; exp_sel[4] = 1'b1; exp_sel[5] = 1'b0;
        mem[0] = 16'hA15C;
        instr_ready = 1'b1;
        redirect_req = 1'b0;
        reset = 1'b1;
        step();
        step();
        checks++;
        if (mem_op !== NOP || mem_sel !== 1'b0 || mem_in !== 8'h00 || instr !== 16'h0000
            || instr_valid !== 1'b0 || redirect_ack !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: op=%0d sel=%b in=%h instr=%h valid=%b ack=%b, required all zero",
                     mem_op, mem_sel, mem_in, instr, instr_valid, redirect_ack);
        end
        reset = 1'b0;
        #1;
        for (n = 0; n < 6; n++) begin
            if (n > 0) step();
            checks++;
            if (mem_op !== exp_op[n] || mem_sel !== exp_sel[n] || instr_valid !== (n == 5)) begin
                errors++;
                $display("FAIL reset_seq cycle %0d: op=%0d sel=%b valid=%b, required op=%0d sel=%b valid=%b",
                         n, mem_op, mem_sel, instr_valid, exp_op[n], exp_sel[n], (n == 5));
            end
        end
        checks++;
        if (instr !== 16'hA15C) begin
            errors++;
            $display("FAIL reset_first_instr: got %h, required a15c", instr);
        end
    endtask

    task automatic test_streaming();
        logic [15:0] exp_instr [0:2];
        int n;
        exp_instr[0] = 16'h0102; exp_instr[1] = 16'h0304; exp_instr[2] = 16'h0506;
        mem[0] = 16'h0102; mem[1] = 16'h0304; mem[2] = 16'h0506;
        instr_ready = 1'b1;
        redirect_req = 1'b0;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            wait_valid(n);
            checks++;
            if (n !== 5) begin
                errors++;
                $display("FAIL stream_gap %0d: %0d edges to valid, required 5", i, n);
            end
            checks++;
            if (instr !== exp_instr[i]) begin
                errors++;
                $display("FAIL stream_instr %0d: got %h, required %h", i, instr, exp_instr[i]);
            end
            step();
            checks++;
            if (mem_op !== REL_ADD || mem_in !== 8'h01 || instr_valid !== 1'b0) begin
                errors++;
                $display("FAIL stream_advance %0d: op=%0d in=%h valid=%b, required op=%0d in=01 valid=0",
                         i, mem_op, mem_in, instr_valid, REL_ADD);
            end
        end
    endtask

    task automatic test_backpressure();
        int n;
        mem[0] = 16'h1111; mem[1] = 16'h2222;
        instr_ready = 1'b0;
        redirect_req = 1'b0;
        do_reset();
        wait_valid(n);
        checks++;
        if (n !== 5 || instr !== 16'h1111) begin
            errors++;
            $display("FAIL bp_first: edges=%0d instr=%h, required 5 and 1111", n, instr);
        end
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (mem_op !== NOP || instr !== 16'h1111 || instr_valid !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold %0d: op=%0d instr=%h valid=%b, required NOP 1111 valid=1",
                         i, mem_op, instr, instr_valid);
            end
        end
        checks++;
        if (mem_addr !== 8'h00) begin
            errors++;
            $display("FAIL bp_addr: address %h, required 00", mem_addr);
        end
        instr_ready = 1'b1;
        step();
        checks++;
        if (mem_op !== REL_ADD || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: op=%0d valid=%b, required op=%0d valid=0", mem_op, instr_valid, REL_ADD);
        end
        wait_valid(n);
        checks++;
        if (instr !== 16'h2222 || mem_addr !== 8'h01) begin
            errors++;
            $display("FAIL bp_next: instr=%h addr=%h, required 2222 and 01", instr, mem_addr);
        end
    endtask

    task automatic test_abs_jump();
        int n;
        mem[0] = 16'h0A0A; mem[8'h40] = 16'h4040;
        instr_ready = 1'b0;
        redirect_req = 1'b0;
        do_reset();
        wait_valid(n);
        redirect_req = 1'b1; redirect_mode = 2'b00; redirect_value = 8'h40;
        instr_ready = 1'b1;
        step();
        redirect_req = 1'b0;
        instr_ready = 1'b0;
        checks++;
        if (redirect_ack !== 1'b1 || mem_op !== ABSOLUTE || mem_in !== 8'h40) begin
            errors++;
            $display("FAIL abs_redirect: ack=%b op=%0d in=%h, required ack=1 op=%0d in=40",
                     redirect_ack, mem_op, mem_in, ABSOLUTE);
        end
        step();
        checks++;
        if (redirect_ack !== 1'b0 || mem_op !== READ) begin
            errors++;
            $display("FAIL abs_ack_pulse: ack=%b op=%0d, required ack=0 op=%0d", redirect_ack, mem_op, READ);
        end
        wait_valid(n);
        checks++;
        if (instr !== 16'h4040 || n !== 4) begin
            errors++;
            $display("FAIL abs_target: instr=%h edges=%0d, required 4040 and 4", instr, n);
        end
    endtask

    task automatic test_relative();
        int n;
        mem[8'h10] = 16'h1010; mem[8'h0D] = 16'h0D0D; mem[8'h0E] = 16'h0E0E;
        instr_ready = 1'b0;
        redirect_req = 1'b0;
        do_reset();
        wait_valid(n);
        redirect_req = 1'b1; redirect_mode = 2'b00; redirect_value = 8'h10;
        instr_ready = 1'b1;
        step();
        redirect_req = 1'b0; instr_ready = 1'b0;
        wait_valid(n);
        checks++;
        if (instr !== 16'h1010) begin
            errors++;
            $display("FAIL rel_setup: instr=%h, required 1010", instr);
        end
        redirect_req = 1'b1; redirect_mode = 2'b10; redirect_value = 8'h03;
        instr_ready = 1'b1;
        step();
        redirect_req = 1'b0; instr_ready = 1'b0;
        checks++;
        if (mem_op !== REL_SUB || mem_in !== 8'h03 || redirect_ack !== 1'b1) begin
            errors++;
            $display("FAIL rel_back_op: op=%0d in=%h ack=%b, required op=%0d in=03 ack=1",
                     mem_op, mem_in, redirect_ack, REL_SUB);
        end
        wait_valid(n);
        checks++;
        if (instr !== 16'h0D0D || mem_addr !== 8'h0D) begin
            errors++;
            $display("FAIL rel_back_target: instr=%h addr=%h, required 0d0d and 0d", instr, mem_addr);
        end
        redirect_req = 1'b1; redirect_mode = 2'b01; redirect_value = 8'h00;
        instr_ready = 1'b1;
        step();
        redirect_req = 1'b0; instr_ready = 1'b0;
        checks++;
        if (mem_op !== REL_ADD || mem_in !== 8'h00 || redirect_ack !== 1'b1) begin
            errors++;
            $display("FAIL rel_fwd_op: op=%0d in=%h ack=%b, required op=%0d in=00 ack=1",
                     mem_op, mem_in, redirect_ack, REL_ADD);
        end
        wait_valid(n);
        checks++;
        if (instr !== 16'h0D0D || mem_addr !== 8'h0D) begin
            errors++;
            $display("FAIL rel_fwd_zero: instr=%h addr=%h, required 0d0d and 0d", instr, mem_addr);
        end
    endtask

    task automatic test_reset_mid_and_reserved();
        int n;
        mem[0] = 16'hC3D4; mem[1] = 16'hE5F6; mem[8'h40] = 16'h4040;
        instr_ready = 1'b0;
        redirect_req = 1'b0;
        do_reset();
        step();
        step();
        step();
        checks++;
        if (mem_op !== READ || mem_sel !== 1'b1 || instr !== 16'hC300) begin
            errors++;
            $display("FAIL mid_rd1a: op=%0d sel=%b instr=%h, required op=%0d sel=1 instr=c300",
                     mem_op, mem_sel, instr, READ);
        end
        reset = 1'b1;
        step();
        checks++;
        if (mem_op !== NOP || mem_sel !== 1'b0 || mem_in !== 8'h00 || instr !== 16'h0000
            || instr_valid !== 1'b0 || redirect_ack !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_zero: op=%0d sel=%b in=%h instr=%h valid=%b ack=%b, required all zero",
                     mem_op, mem_sel, mem_in, instr, instr_valid, redirect_ack);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (mem_op !== ABSOLUTE || mem_in !== 8'h00) begin
            errors++;
            $display("FAIL mid_restart_load: op=%0d in=%h, required op=%0d in=00", mem_op, mem_in, ABSOLUTE);
        end
        wait_valid(n);
        checks++;
        if (n !== 5 || instr !== 16'hC3D4) begin
            errors++;
            $display("FAIL mid_restart_instr: edges=%0d instr=%h, required 5 and c3d4", n, instr);
        end
        redirect_req = 1'b1; redirect_mode = 2'b11; redirect_value = 8'h40;
        instr_ready = 1'b1;
        step();
        redirect_req = 1'b0; instr_ready = 1'b0;
        checks++;
        if (mem_op !== REL_ADD || mem_in !== 8'h01 || redirect_ack !== 1'b0) begin
            errors++;
            $display("FAIL reserved_mode: op=%0d in=%h ack=%b, required op=%0d in=01 ack=0",
                     mem_op, mem_in, redirect_ack, REL_ADD);
        end
        wait_valid(n);
        checks++;
        if (instr !== 16'hE5F6) begin
            errors++;
            $display("FAIL reserved_next: instr=%h, required e5f6", instr);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        instr_ready = 1'b0;
        redirect_req = 1'b0;
        redirect_mode = 2'b00;
        redirect_value = 8'h00;
        mem_addr = 8'h00;
        mem_out = 8'h00;
        for (int i = 0; i < 256; i++) mem[i] = 16'hFFFF;
        test_reset();
        test_streaming();
        test_backpressure();
        test_abs_jump();
        test_relative();
        test_reset_mid_and_reserved();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction fetch sequencer that sits directly upstream of `memory` and drives its `op`, `data_word_selector` and `in` inputs. It reads each 16-bit instruction as two bytes: selector 0 is the opcode and selector 1 is the operand. It moves the memory address register forward after each instruction, or redirects it on a jump, and hands the assembled instruction to the decoder over a valid/ready handshake.

## Interface
Parameters:
- `RESET_VECTOR`, default 8'h00: word address loaded through ABSOLUTE after reset.

Ports:
- `clock`  in  1  single clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-high.
- `mem_op`  out  memory_op_e  drives `memory.op`. NOP is the enum's no-operation member.
- `mem_data_word_selector`  out  1  drives `memory.data_word_selector`.
- `mem_in`  out  8  drives `memory.in`. Value is 8'h00 whenever `mem_op` is not ABSOLUTE, REL_ADD or REL_SUB.
- `mem_out`  in  8  from `memory.out`. Valid only while `mem_op`==READ.
- `instr`  out  16  held instruction: {opcode, operand}.
- `instr_valid`  out  1  `instr` is held and waiting for the decoder.
- `instr_ready`  in  1  decoder accepts `instr`.
- `redirect_req`  in  1  decoder requests a jump. Sampled only on an accepting handshake.
- `redirect_mode`  in  2  2'b00 ABS, 2'b01 FWD (REL_ADD), 2'b10 BACK (REL_SUB), 2'b11 reserved.
- `redirect_value`  in  8  absolute target or unsigned relative magnitude.
- `redirect_ack`  out  1  one-cycle pulse while the redirect op is on `mem_op`.

## Operation
- States: LOAD, RD0A, RD0B, RD1A, RD1B, HOLD, ADVANCE, REDIRECT.
- LOAD:
  - mem_op=ABSOLUTE, mem_in=RESET_VECTOR.
  - Next state RD0A.
- RD0A and RD0B:
  - mem_op=READ, selector=0.
  - The memory registers its read at the RD0A posedge and drives `mem_out` during RD0B.
  - At the RD0B posedge, `instr[15:8]` <= `mem_out`.
  - Next state RD1A.
- RD1A and RD1B:
  - Same as RD0A/RD0B but with selector=1, capturing `instr[7:0]` at the RD1B posedge.
  - Next state HOLD.
- HOLD:
  - mem_op=NOP, instr_valid=1, instr stable.
  - Handshake = instr_valid && instr_ready.
  - On a handshake with redirect_req=1 and mode≠2'b11: go to REDIRECT and latch mode and value.
  - On a handshake otherwise (no request, or reserved mode): go to ADVANCE.
  - No handshake: stay in HOLD.
- ADVANCE:
  - mem_op=REL_ADD, mem_in=8'h01.
  - Next state RD0A.
- REDIRECT:
  - mem_op=ABSOLUTE, REL_ADD or REL_SUB per the latched mode, mem_in=latched value, redirect_ack=1.
  - Next state RD0A.
- Relative redirects are measured from the word address of the instruction just accepted, because ADVANCE is skipped.
  - FWD with value 0 refetches the same word.
  - Address wrap-around is the memory's modular arithmetic. The fetcher does not check it.
- redirect_req outside an accepting handshake is ignored. There is no queuing.
- The selector is 0 in every state except RD1A and RD1B.

## Timing
- While reset=1 at a posedge, state goes to LOAD and all outputs are zero:
  - mem_op=NOP, selector=0, mem_in=0.
  - instr=16'h0000, instr_valid=0, redirect_ack=0.
- Reset takes effect mid-read as well, discarding any partial instruction.
- Outputs are registered from the state and the held data. mem_in comes from the state plus the latched redirect value.
- First-instruction latency:
  - Cycle 0 is the first cycle with reset=0 (LOAD).
  - Cycles 1–4 are the reads.
  - instr_valid rises in cycle 5.
- Throughput with instr_ready tied high: one instruction every 6 cycles (HOLD, ADVANCE/REDIRECT, 4 reads).
- instr_valid falls in the cycle after the handshake and stays low until the next RD1B capture.
- instr does not change while instr_valid=1.

## Test plan
- Reset latency:
  - Stimulus: word 0 = {8'hA1, 8'h5C}, RESET_VECTOR=0, ready=1.
  - Required: instr_valid first high in cycle 5 with instr=16'hA15C, and mem_op sequence ABSOLUTE, READ×4, NOP.
- Streaming:
  - Stimulus: words 0..2 = 16'h0102, 16'h0304, 16'h0506, ready=1.
  - Required: three handshakes 6 cycles apart, in order, with one REL_ADD(1) between them.
- Backpressure:
  - Stimulus: hold ready=0 for 10 cycles in HOLD.
  - Required: mem_op=NOP throughout, instr unchanged, no address change, and the next fetch is from word 1 after ready rises.
- Absolute jump:
  - Stimulus: accept with req=1, mode ABS, value 8'h40.
  - Required: redirect_ack for one cycle, mem_op=ABSOLUTE with mem_in=8'h40, and the next instr comes from word 0x40.
- Relative branches:
  - Stimulus: at word 0x10, BACK 3; then at word 0x0D, FWD 0.
  - Required: fetch from 0x0D, then 0x0D again.
- Reset mid-operation plus reserved mode:
  - Stimulus: assert reset during RD1A; separately, accept with mode 2'b11.
  - Required: after the reset, outputs are zero and fetching restarts at RESET_VECTOR. The reserved mode behaves as ADVANCE with no redirect_ack.
